// File: rtl/data_mem_unit.sv
// Byte-addressable data memory with sized, sign/zero-extending loads, a valid/ready request port,
// a one-cycle registered response with fault flags, and a hardware zero-fill sequence.
module data_mem_unit #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [1:0]       req_size,
    input  logic             req_signed,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_misalign,
    output logic             rsp_range
);

    localparam int NB    = WIDTH / 8;
    localparam int OFFS  = $clog2(NB);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int AW    = ADDR_W + OFFS;
    localparam logic [1:0] MAX_SIZE = 2'(OFFS);

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [WIDTH-1:0]  mem [DEPTH];

    // Keeps the low 8<<size bits of raw and fills the rest with the field MSB or zero.
    function automatic logic [WIDTH-1:0] load_extend(input logic [WIDTH-1:0] raw,
                                                     input logic [1:0]       size,
                                                     input logic             sgn);
        logic [WIDTH-1:0] fmask;
        logic [WIDTH-1:0] top;
        fmask = (WIDTH'(1) << (8'd8 << size)) - WIDTH'(1);
        top   = fmask & ~(fmask >> 1);
        if (sgn && |(raw & top))
            return raw | ~fmask;
        return raw & fmask;
    endfunction

    // Stage p0: request decode, fault checks and lane steering
    logic [OFFS-1:0]   off_p0;
    logic [ADDR_W-1:0] idx_p0;
    logic [OFFS-1:0]   align_mask_p0;
    logic              misalign_p0;
    logic              range_p0;
    logic              accept_p0;
    logic              store_p0;
    logic [3:0]        nbytes_p0;
    logic [NB-1:0]     bmask_p0;
    logic [WIDTH-1:0]  wmask_p0;
    logic [WIDTH-1:0]  wshift_p0;
    logic [WIDTH-1:0]  word_p0;
    logic [WIDTH-1:0]  load_p0;

    assign off_p0        = req_addr[OFFS-1:0];
    assign idx_p0        = req_addr[AW-1:OFFS];
    assign align_mask_p0 = OFFS'((4'd1 << req_size) - 4'd1);
    assign misalign_p0   = (req_size > MAX_SIZE) || ((off_p0 & align_mask_p0) != '0);
    // Any set bit above the array span is a fault, so high bits can never alias.
    assign range_p0      = |req_addr[WIDTH-1:AW];
    assign accept_p0     = req_valid && req_ready;
    assign store_p0      = accept_p0 && req_write && !misalign_p0 && !range_p0;

    assign nbytes_p0 = 4'd1 << req_size;
    assign bmask_p0  = ((NB'(1) << nbytes_p0) - NB'(1)) << off_p0;
    assign wshift_p0 = req_wdata << {off_p0, 3'b000};
    assign word_p0   = mem[idx_p0];
    assign load_p0   = load_extend(word_p0 >> {off_p0, 3'b000}, req_size, req_signed);

    for (genvar b = 0; b < NB; b++) begin : g_lane
        assign wmask_p0[8*b +: 8] = {8{bmask_p0[b]}};
    end

    // Stage p1: array update and registered response
    always_ff @(posedge clk) begin
        if (state == CLEAR)
            mem[clr_ptr] <= '0;
        else if (store_p0)
            mem[idx_p0] <= (word_p0 & ~wmask_p0) | (wshift_p0 & wmask_p0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= CLEAR;
            clr_ptr      <= '0;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_misalign <= 1'b0;
            rsp_range    <= 1'b0;
        end else begin
            rsp_valid <= accept_p0;
            if (accept_p0) begin
                rsp_misalign <= misalign_p0;
                rsp_range    <= !misalign_p0 && range_p0;
                rsp_rdata    <= (req_write || misalign_p0 || range_p0) ? '0 : load_p0;
            end
            case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
                        state     <= READY;
                        req_ready <= 1'b1;
                    end
                end
                READY: begin
                    // A request accepted alongside clr still completes above.
                    if (clr) begin
                        state     <= CLEAR;
                        clr_ptr   <= '0;
                        req_ready <= 1'b0;
                    end
                end
                default: begin
                    state     <= CLEAR;
                    clr_ptr   <= '0;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: directed scenarios plus randomized traffic against a byte-array model.
module tb_data_mem_unit;

    localparam int W    = 32;
    localparam int AW   = 6;
    localparam int MEMB = (1 << AW) * (W / 8);

    logic         clk = 1'b0;
    logic         rst, clr, req_valid, req_ready, req_write, req_signed;
    logic [1:0]   req_size;
    logic [W-1:0] req_addr, req_wdata, rsp_rdata;
    logic         rsp_valid, rsp_misalign, rsp_range;

    int checks = 0;
    int errors = 0;
    logic [7:0] mb [MEMB];

    data_mem_unit #(.WIDTH(W), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_misalign(rsp_misalign), .rsp_range(rsp_range)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Byte-array reference: returns expected response and applies stores.
    task automatic model(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] er, output logic em, output logic erng);
        int nb;
        longint v;
        nb   = 1 << sz;
        em   = (sz > 2) || (a % nb != 0);
        erng = !em && (a >= MEMB);
        er   = 32'h0;
        if (em || erng) return;
        if (w) begin
            for (int i = 0; i < nb; i++) mb[8'(int'(a) + i)] = 8'(wd >> (8 * i));
        end else begin
            v = 0;
            for (int i = 0; i < nb; i++) v = v | (longint'(mb[8'(int'(a) + i)]) << (8 * i));
            if (sg && nb < 4 && ((v >> (8 * nb - 1)) & 1) != 0) v = v - (longint'(1) << (8 * nb));
            er = 32'(v);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < MEMB; i++) mb[i] = 8'h00;
    endtask

    task automatic send(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input logic c,
                        output logic ov, output logic [31:0] ord, output logic om, output logic orr);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd; clr = c;
        @(posedge clk); #1;
        ov = rsp_valid; ord = rsp_rdata; om = rsp_misalign; orr = rsp_range;
        req_valid = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        logic ov, om, orr;
        logic [31:0] ord;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 ||
            rsp_misalign !== 1'b0 || rsp_range !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b rdata=%h mis=%b rng=%b want all 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_misalign, rsp_range);
        end
        rst = 1'b0;
        n = 0;
        while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
        checks++;
        if (n != 64) begin
            errors++;
            $display("FAIL reset_clear_len: got %0d cycles want 64", n);
        end
        model_clear();
        send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, ov, ord, om, orr);
        checks++;
        if (ov !== 1'b1 || ord !== 32'h0) begin
            errors++;
            $display("FAIL reset_lw: got vld=%b rdata=%h want vld=1 rdata=00000000", ov, ord);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rsp_pulse: got vld=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_store_load();
        logic [1:0]  sz [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
        logic        sg [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] ad [4] = '{32'h20, 32'h23, 32'h22, 32'h22};
        logic [31:0] ex [4] = '{32'hFFFFFFF1, 32'h00000080, 32'hFFFF8000, 32'h00008000};
        logic ov, om, orr, em, en;
        logic [31:0] ord, er;
        model(1'b1, 2'd2, 1'b0, 32'h20, 32'h800000F1, er, em, en);
        send(1'b1, 2'd2, 1'b0, 32'h20, 32'h800000F1, 1'b0, ov, ord, om, orr);
        checks++;
        if (ov !== 1'b1 || ord !== 32'h0 || om !== 1'b0 || orr !== 1'b0) begin
            errors++;
            $display("FAIL sw_rsp: got vld=%b rdata=%h mis=%b rng=%b want 1 0 0 0", ov, ord, om, orr);
        end
        for (int i = 0; i < 4; i++) begin
            model(1'b0, sz[i], sg[i], ad[i], 32'h0, er, em, en);
            send(1'b0, sz[i], sg[i], ad[i], 32'h0, 1'b0, ov, ord, om, orr);
            checks++;
            if (ov !== 1'b1 || ord !== ex[i] || om !== 1'b0 || orr !== 1'b0) begin
                errors++;
                $display("FAIL narrow_load[%0d]: got vld=%b rdata=%h want rdata=%h", i, ov, ord, ex[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic ov, om, orr, em, en;
        logic [31:0] ord, er;
        model(1'b1, 2'd1, 1'b0, 32'h22, 32'h1234, er, em, en);
        send(1'b1, 2'd1, 1'b0, 32'h22, 32'h00001234, 1'b0, ov, ord, om, orr);
        checks++;
        if (ov !== 1'b1 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_sh: got vld=%b rdy=%b want 1 1", ov, req_ready);
        end
        model(1'b1, 2'd0, 1'b0, 32'h21, 32'hAB, er, em, en);
        send(1'b1, 2'd0, 1'b0, 32'h21, 32'h000000AB, 1'b0, ov, ord, om, orr);
        checks++;
        if (ov !== 1'b1) begin
            errors++;
            $display("FAIL b2b_sb: got vld=%b want 1", ov);
        end
        model(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, er, em, en);
        send(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, ov, ord, om, orr);
        checks++;
        if (ov !== 1'b1 || ord !== 32'h1234ABF1) begin
            errors++;
            $display("FAIL b2b_lw: got vld=%b rdata=%h want 1234abf1", ov, ord);
        end
    endtask

    task automatic test_faults();
        logic        fw [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [1:0]  fz [5] = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd2};
        logic [31:0] fa [5] = '{32'h21, 32'h102, 32'h100, 32'h20, 32'h00};
        logic        xm [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        xr [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic ov, om, orr, em, en;
        logic [31:0] ord, er;
        for (int i = 0; i < 5; i++) begin
            model(fw[i], fz[i], 1'b0, fa[i], 32'hDEADBEEF, er, em, en);
            send(fw[i], fz[i], 1'b0, fa[i], 32'hDEADBEEF, 1'b0, ov, ord, om, orr);
            checks++;
            if (ov !== 1'b1 || ord !== 32'h0 || om !== xm[i] || orr !== xr[i]) begin
                errors++;
                $display("FAIL fault[%0d]: got vld=%b rdata=%h mis=%b rng=%b want 1 00000000 %b %b",
                         i, ov, ord, om, orr, xm[i], xr[i]);
            end
        end
    endtask

    task automatic test_random();
        logic ov, om, orr, em, en, w, sg;
        logic [1:0] sz;
        logic [31:0] ord, er, a, wd, hold;
        hold = 32'h0;
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                checks++;
                if (rsp_valid !== 1'b0 || rsp_rdata !== hold) begin
                    errors++;
                    $display("FAIL idle_hold[%0d]: got vld=%b rdata=%h want 0 %h", it, rsp_valid, rsp_rdata, hold);
                end
            end else begin
                sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                a  = 32'($urandom_range(0, MEMB - 1));
                if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
                if ($urandom_range(0, 9) == 0) a = a | (32'd1 << $urandom_range(8, 31));
                w  = 1'($urandom_range(0, 1));
                sg = 1'($urandom_range(0, 1));
                wd = $urandom;
                model(w, sz, sg, a, wd, er, em, en);
                send(w, sz, sg, a, wd, 1'b0, ov, ord, om, orr);
                hold = er;
                checks++;
                if (ov !== 1'b1 || ord !== er || om !== em || orr !== en) begin
                    errors++;
                    $display("FAIL random[%0d] w=%b sz=%0d a=%h: got vld=%b rdata=%h mis=%b rng=%b want 1 %h %b %b",
                             it, w, sz, a, ov, ord, om, orr, er, em, en);
                end
            end
        end
    endtask

    task automatic test_clr();
        int n;
        logic ov, om, orr, em, en;
        logic [31:0] ord, er;
        model(1'b1, 2'd2, 1'b0, 32'h20, 32'h5A5AC3C3, er, em, en);
        send(1'b1, 2'd2, 1'b0, 32'h20, 32'h5A5AC3C3, 1'b0, ov, ord, om, orr);
        model(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, er, em, en);
        send(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1, ov, ord, om, orr);
        checks++;
        if (ov !== 1'b1 || ord !== 32'h5A5AC3C3) begin
            errors++;
            $display("FAIL clr_load: got vld=%b rdata=%h want 1 5a5ac3c3", ov, ord);
        end
        n = 0;
        while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
        checks++;
        if (n != 64) begin
            errors++;
            $display("FAIL clr_len: got %0d cycles want 64", n);
        end
        model_clear();
        send(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, ov, ord, om, orr);
        checks++;
        if (ov !== 1'b1 || ord !== 32'h0) begin
            errors++;
            $display("FAIL clr_after: got vld=%b rdata=%h want 1 00000000", ov, ord);
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        logic ov, om, orr, em, en;
        logic [31:0] ord, er;
        model(1'b1, 2'd2, 1'b0, 32'hF0, 32'hCAFEF00D, er, em, en);
        send(1'b1, 2'd2, 1'b0, 32'hF0, 32'hCAFEF00D, 1'b0, ov, ord, om, orr);
        send(1'b0, 2'd2, 1'b0, 32'hF0, 32'h0, 1'b0, ov, ord, om, orr);
        checks++;
        if (ord !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL pre_clear_lw: got %h want cafef00d", ord);
        end
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0 || rsp_rdata !== 32'h0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL midclr_reset: got rdy=%b vld=%b rdata=%h want 0 0 00000000",
                     req_ready, rsp_valid, rsp_rdata);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
        checks++;
        if (n != 64) begin
            errors++;
            $display("FAIL midclr_len: got %0d cycles want 64", n);
        end
        model_clear();
        send(1'b0, 2'd2, 1'b0, 32'hF0, 32'h0, 1'b0, ov, ord, om, orr);
        checks++;
        if (ov !== 1'b1 || ord !== 32'h0) begin
            errors++;
            $display("FAIL midclr_after: got vld=%b rdata=%h want 1 00000000", ov, ord);
        end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_size = 2'd0; req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        test_reset();
        test_store_load();
        test_back_to_back();
        test_faults();
        test_random();
        test_clr();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
